adc_spi_responder: RTL

Synthesizable SPI responder that emulates the ADC end of the FPGA/ADC sample link. It serves a frame of leading null bits followed by one MSB-first sample on `sdo` each time the initiator raises `chip_en` and toggles `sclk`. The block is used for loopback and hardware-in-the-loop checks of the SPI read FSM without a physical converter. It sits on the system clock and oversamples the SPI pins, and a producer loads new samples through a simple valid interface.

---
 rtl/adc_spi_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/adc_spi_responder.sv
// SPI responder that stands in for the ADC: serves LEAD_ZEROS null bits followed by an
// MSB-first sample on sdo, with sclk/chip_en oversampled on the system clock.
module adc_spi_responder #(
    parameter int DATA_W     = 10,
    parameter int LEAD_ZEROS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              chip_en,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              sdo,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              stale,
    output logic              overrun
);

    localparam int F  = LEAD_ZEROS + DATA_W;
    localparam int CW = $clog2(F + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_t;

    // Bit 0 carries sclk, bit 1 carries chip_en.
    logic [1:0] pin_raw;
    logic [1:0] sync1_reg, sync2_reg, hist_reg;

    assign pin_raw = {chip_en, sclk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                    hist_reg[gi]  <= 1'b0;
                end else begin
                    sync1_reg[gi] <= pin_raw[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                    hist_reg[gi]  <= sync2_reg[gi];
                end
            end
        end
    endgenerate

    logic sclk_fall, cs_rise, cs_fall;
    assign sclk_fall = hist_reg[0] & ~sync2_reg[0];
    assign cs_rise   = sync2_reg[1] & ~hist_reg[1];
    assign cs_fall   = hist_reg[1] & ~sync2_reg[1];

    state_t              state_reg, state_next;
    logic [F-1:0]        shift_reg, shift_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [DATA_W-1:0]   hold_reg, hold_next;
    logic                fresh_reg, fresh_next;
    logic                sdo_reg, sdo_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                abort_reg, abort_next;
    logic                stale_reg, stale_next;
    logic                overrun_reg, overrun_next;
    logic                frame_start;

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        cnt_next    = cnt_reg;
        stale_next  = stale_reg;
        done_next   = 1'b0;
        abort_next  = 1'b0;
        frame_start = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cs_rise) begin
                    frame_start = 1'b1;
                    shift_next  = F'(hold_reg);
                    stale_next  = ~fresh_reg;
                    cnt_next    = CW'(F - 1);
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                // A falling chip_en takes priority over a coincident sclk edge.
                if (cs_fall) begin
                    abort_next = 1'b1;
                    state_next = IDLE;
                end else if (sclk_fall) begin
                    shift_next = {shift_reg[F-2:0], 1'b0};
                    cnt_next   = cnt_reg - CW'(1);
                    if (cnt_reg == '0) begin
                        done_next  = 1'b1;
                        state_next = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (cs_fall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        sdo_next  = (state_next == SHIFT) ? shift_next[F-1] : 1'b0;
        busy_next = (state_next != IDLE);
    end

    // A sample consumed by the starting frame is not overrun by same-cycle new data.
    always_comb begin
        hold_next    = hold_reg;
        fresh_next   = fresh_reg;
        overrun_next = 1'b0;
        if (sample_valid) begin
            hold_next    = sample_data;
            fresh_next   = 1'b1;
            overrun_next = fresh_reg & ~frame_start;
        end else if (frame_start) begin
            fresh_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            hold_reg    <= '0;
            fresh_reg   <= 1'b0;
            sdo_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            abort_reg   <= 1'b0;
            stale_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            hold_reg    <= hold_next;
            fresh_reg   <= fresh_next;
            sdo_reg     <= sdo_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            abort_reg   <= abort_next;
            stale_reg   <= stale_next;
            overrun_reg <= overrun_next;
        end
    end

    assign sdo         = sdo_reg;
    assign busy        = busy_reg;
    assign frame_done  = done_reg;
    assign frame_abort = abort_reg;
    assign stale       = stale_reg;
    assign overrun     = overrun_reg;

endmodule
